// File: rtl/float_acc_pkg.sv
// float_acc_pkg: shared definitions for the float16 vector accumulator.
//   FP16_W / FP16_EXP_W / FP16_FRAC_W : float16 field widths {sign, exp, frac}
//   FP16_EXP_MAX                      : all-ones exponent (inf / NaN encoding)
//   acc_state_e                       : accumulator FSM states
//   fp16_exp_is_max()                 : true when a word carries the all-ones exponent
package float_acc_pkg;

    localparam int FP16_W      = 16;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_FRAC_W = 10;

    localparam logic [FP16_EXP_W-1:0] FP16_EXP_MAX = 5'h1F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FOLD  = 2'd2,
        OUT   = 2'd3
    } acc_state_e;

    function automatic logic fp16_exp_is_max(input logic [FP16_W-1:0] x);
        return x[FP16_FRAC_W +: FP16_EXP_W] == FP16_EXP_MAX;
    endfunction

endpackage

// File: rtl/float_acc_tagline.sv
// float_acc_tagline: DEPTH-stage shift register carrying {valid, slot index}
// alongside the external adder pipeline, so each returning result knows which
// slot it belongs to.
//   clock, rst_n  : clock, asynchronous active-low clear of every stage
//   push_valid_i  : tag valid entering stage 0
//   push_idx_i    : slot index entering stage 0
//   pop_valid_o   : tag valid leaving the last stage
//   pop_idx_o     : slot index leaving the last stage
module float_acc_tagline #(
    parameter int DEPTH = 6,
    parameter int IDX_W = 3
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             push_valid_i,
    input  logic [IDX_W-1:0] push_idx_i,
    output logic             pop_valid_o,
    output logic [IDX_W-1:0] pop_idx_o
);

    logic             vld_q [DEPTH];
    logic [IDX_W-1:0] idx_q [DEPTH];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                vld_q[k] <= 1'b0;
                idx_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= push_valid_i;
            idx_q[0] <= push_idx_i;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
                idx_q[k] <= idx_q[k-1];
            end
        end
    end

    assign pop_valid_o = vld_q[DEPTH-1];
    assign pop_idx_o   = idx_q[DEPTH-1];

endmodule

// File: rtl/float_vec_acc.sv
// float_vec_acc: sums a stream of float16 vectors using an external
// fixed-latency float16 adder. ADD_LAT partial-sum slots are filled round
// robin so the adder can take a new element every cycle; after the last
// element the slots are folded pairwise down to one result.
//   clock, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready   : element handshake; in_data = float16, in_last = final element
//   add_a, add_b        : adder operands (held between issues)
//   add_c               : adder result, ADD_LAT cycles after the operands appear
//   out_valid, out_data : one-cycle pulse with the vector sum
//   out_inf             : only with FLOAT_VEC_ACC_INF_DET_EN defined; pulses with
//                         out_valid when any adder result of the vector had exp=1F
//
// state | meaning
// IDLE  | waiting for the first element of a vector, ptr held at 0
// ACCUM | taking elements, ptr walks the slots every cycle
// FOLD  | combining slots pairwise until one remains and nothing is in flight
// OUT   | presenting the sum for one cycle, then clearing the slots
module float_vec_acc
    import float_acc_pkg::*;
#(
    parameter int ADD_LAT = 6
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP16_W-1:0] in_data,
    input  logic              in_last,
    output logic [FP16_W-1:0] add_a,
    output logic [FP16_W-1:0] add_b,
    input  logic [FP16_W-1:0] add_c,
    output logic              out_valid,
    output logic [FP16_W-1:0] out_data
`ifdef FLOAT_VEC_ACC_INF_DET_EN
    ,
    output logic              out_inf
`endif
);

    localparam int            PW       = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(ADD_LAT - 1);

    acc_state_e        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [FP16_W-1:0] slot_q [ADD_LAT];
    logic [FP16_W-1:0] slot_d [ADD_LAT];
    logic [ADD_LAT-1:0] empty_q, empty_d;
    logic [ADD_LAT-1:0] inflight_q, inflight_d;
    logic [FP16_W-1:0] add_a_q, add_a_d;
    logic [FP16_W-1:0] add_b_q, add_b_d;
    logic              tag_vld_q, tag_vld_d;
    logic [PW-1:0]     tag_idx_q, tag_idx_d;
    logic              out_valid_q, out_valid_d;
    logic [FP16_W-1:0] out_data_q, out_data_d;
`ifdef FLOAT_VEC_ACC_INF_DET_EN
    logic              inf_seen_q, inf_seen_d;
    logic              out_inf_q, out_inf_d;
`endif

    logic              pop_vld;
    logic [PW-1:0]     pop_idx;
    logic              accept;
    logic [PW-1:0]     ptr_inc;
    logic [ADD_LAT-1:0] avail;
    logic              found_i, found_j;
    logic [PW-1:0]     fold_i, fold_j;
    logic [FP16_W-1:0] out_sel;

    // The tag line is fed from the registered issue tag, so its last stage
    // lines up with add_c exactly ADD_LAT cycles after the operands appear.
    float_acc_tagline #(
        .DEPTH (ADD_LAT),
        .IDX_W (PW)
    ) u_tagline (
        .clock        (clock),
        .rst_n        (rst_n),
        .push_valid_i (tag_vld_q),
        .push_idx_i   (tag_idx_q),
        .pop_valid_o  (pop_vld),
        .pop_idx_o    (pop_idx)
    );

    assign in_ready = (state_q == IDLE) || ((state_q == ACCUM) && !inflight_q[ptr_q]);
    assign accept   = in_valid && in_ready;
    assign ptr_inc  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    assign avail    = ~empty_q & ~inflight_q;

    always_comb begin
        found_i = 1'b0;
        found_j = 1'b0;
        fold_i  = '0;
        fold_j  = '0;
        for (int k = 0; k < ADD_LAT; k++) begin
            if (avail[k]) begin
                if (!found_i) begin
                    found_i = 1'b1;
                    fold_i  = PW'(k);
                end else if (!found_j) begin
                    found_j = 1'b1;
                    fold_j  = PW'(k);
                end
            end
        end
    end

    always_comb begin
        out_sel = '0;
        for (int k = ADD_LAT - 1; k >= 0; k--) begin
            if (!empty_q[k]) out_sel = slot_q[k];
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        slot_d      = slot_q;
        empty_d     = empty_q;
        inflight_d  = inflight_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        tag_vld_d   = 1'b0;
        tag_idx_d   = tag_idx_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
`ifdef FLOAT_VEC_ACC_INF_DET_EN
        inf_seen_d  = inf_seen_q;
        out_inf_d   = 1'b0;
`endif

        // A returning slot is in flight, so nothing below can touch it this cycle.
        if (pop_vld) begin
            slot_d[pop_idx]     = add_c;
            inflight_d[pop_idx] = 1'b0;
`ifdef FLOAT_VEC_ACC_INF_DET_EN
            if (fp16_exp_is_max(add_c)) inf_seen_d = 1'b1;
`endif
        end

        case (state_q)
            IDLE, ACCUM: begin
                ptr_d = (state_q == ACCUM) ? ptr_inc : '0;
                if (accept) begin
                    ptr_d = ptr_inc;
                    if (empty_q[ptr_q]) begin
                        slot_d[ptr_q]  = in_data;
                        empty_d[ptr_q] = 1'b0;
                    end else begin
                        add_a_d           = slot_q[ptr_q];
                        add_b_d           = in_data;
                        inflight_d[ptr_q] = 1'b1;
                        tag_vld_d         = 1'b1;
                        tag_idx_d         = ptr_q;
                    end
                    state_d = in_last ? FOLD : ACCUM;
                end
            end
            FOLD: begin
                if (found_j) begin
                    add_a_d            = slot_q[fold_i];
                    add_b_d            = slot_q[fold_j];
                    empty_d[fold_j]    = 1'b1;
                    inflight_d[fold_i] = 1'b1;
                    tag_vld_d          = 1'b1;
                    tag_idx_d          = fold_i;
                end else if ($onehot(~empty_q) && (inflight_q == '0)) begin
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                    out_data_d  = out_sel;
`ifdef FLOAT_VEC_ACC_INF_DET_EN
                    out_inf_d   = inf_seen_q;
`endif
                end
            end
            OUT: begin
                empty_d = '1;
                ptr_d   = '0;
                state_d = IDLE;
`ifdef FLOAT_VEC_ACC_INF_DET_EN
                inf_seen_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            for (int k = 0; k < ADD_LAT; k++) slot_q[k] <= '0;
            empty_q     <= '1;
            inflight_q  <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            tag_vld_q   <= 1'b0;
            tag_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef FLOAT_VEC_ACC_INF_DET_EN
            inf_seen_q  <= 1'b0;
            out_inf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            for (int k = 0; k < ADD_LAT; k++) slot_q[k] <= slot_d[k];
            empty_q     <= empty_d;
            inflight_q  <= inflight_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            tag_vld_q   <= tag_vld_d;
            tag_idx_q   <= tag_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef FLOAT_VEC_ACC_INF_DET_EN
            inf_seen_q  <= inf_seen_d;
            out_inf_q   <= out_inf_d;
`endif
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef FLOAT_VEC_ACC_INF_DET_EN
    assign out_inf   = out_inf_q;
`endif

endmodule

// File: tb/tb_float_vec_acc.sv
// tb_float_vec_acc: directed bench for float_vec_acc with ADD_LAT=6. The
// external adder is modelled as an exact float16 add delayed six cycles.
module tb_float_vec_acc;

    localparam int ADD_LAT = 6;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] add_c;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_inf_w;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    float_vec_acc #(.ADD_LAT(ADD_LAT)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c     (add_c),
        .out_valid (out_valid),
        .out_data  (out_data)
`ifdef FLOAT_VEC_ACC_INF_DET_EN
        ,
        .out_inf   (out_inf_w)
`endif
    );

`ifndef FLOAT_VEC_ACC_INF_DET_EN
    assign out_inf_w = 1'b0;
`endif

    // ---------------- float16 reference adder ----------------
    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int k = 0; k < e; k++) r = r * 2.0;
        else        for (int k = 0; k < -e; k++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp16_to_real(input logic [15:0] h);
        int  e;
        real m;
        real r;
        e = int'(h[14:10]);
        m = real'(int'(h[9:0])) / 1024.0;
        if (e == 0) r = m * pow2(-14);
        else        r = (1.0 + m) * pow2(e - 15);
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] real_to_fp16(input real v);
        logic s;
        real  a;
        int   e;
        int   f;
        s = (v < 0.0);
        a = s ? -v : v;
        if (a == 0.0)     return {s, 15'h0};
        if (a >= 65520.0) return {s, 5'h1F, 10'h0};
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while ((a < 1.0) && (e > 1)) begin a = a * 2.0; e--; end
        if (a < 1.0) begin
            f = $rtoi(a * 1024.0 + 0.5);
            return {s, 15'(f)};
        end
        f = $rtoi((a - 1.0) * 1024.0 + 0.5);
        if (f == 1024) begin f = 0; e++; end
        if (e >= 31) return {s, 5'h1F, 10'h0};
        return {s, 5'(e), 10'(f)};
    endfunction

    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        if ((a[14:10] == 5'h1F) || (b[14:10] == 5'h1F)) return 16'h7C00;
        return real_to_fp16(fp16_to_real(a) + fp16_to_real(b));
    endfunction

    logic [15:0] pipe [ADD_LAT];
    initial for (int k = 0; k < ADD_LAT; k++) pipe[k] = 16'h0;
    always @(posedge clock) begin
        pipe[0] <= fp16_add(add_a, add_b);
        for (int k = 1; k < ADD_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign add_c = pipe[ADD_LAT-1];

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic send(input logic [15:0] d, input logic last, output int acc_cyc, output int stalls);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        stalls   = 0;
        acc_cyc  = -1;
        n        = 0;
        while ((acc_cyc < 0) && (n < 200)) begin
            if (in_ready) acc_cyc = cyc;
            else          stalls++;
            @(negedge clock);
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (acc_cyc < 0) begin
            failures++;
            $display("FAIL send_timeout: element %h not accepted within 200 cycles", d);
        end
    endtask

    task automatic watch_out(input int window, output int first_cyc, output logic [15:0] data,
                             output int pulses, output logic inf);
        first_cyc = -1;
        data      = 16'h0;
        pulses    = 0;
        inf       = 1'b0;
        for (int n = 0; n < window; n++) begin
            if (out_valid) begin
                pulses++;
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    data      = out_data;
                    inf       = out_inf_w;
                end
            end
            @(negedge clock);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0;
        in_last  = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        checks++; if (add_a !== 16'h0) begin failures++; $display("FAIL reset_add_a: got %h want 0000", add_a); end
        checks++; if (add_b !== 16'h0) begin failures++; $display("FAIL reset_add_b: got %h want 0000", add_b); end
`ifdef FLOAT_VEC_ACC_INF_DET_EN
        checks++; if (out_inf_w !== 1'b0) begin failures++; $display("FAIL reset_out_inf: got %b want 0", out_inf_w); end
`endif
        rst_n = 1'b1;
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        int ac, st, fc, np;
        logic [15:0] d;
        logic inf;
        send(16'h3C00, 1'b1, ac, st);
        watch_out(30, fc, d, np, inf);
        checks++; if (fc - ac != 2) begin failures++; $display("FAIL single_latency: got %0d want 2", fc - ac); end
        checks++; if (d !== 16'h3C00) begin failures++; $display("FAIL single_data: got %h want 3c00", d); end
        checks++; if (np != 1) begin failures++; $display("FAIL single_pulses: got %0d want 1", np); end
        checks++; if (add_a !== 16'h0) begin failures++; $display("FAIL single_no_issue_a: got %h want 0000", add_a); end
        checks++; if (add_b !== 16'h0) begin failures++; $display("FAIL single_no_issue_b: got %h want 0000", add_b); end
    endtask

    task automatic test_back_to_back();
        int ac0, ac1, st, fc, np;
        logic [15:0] d;
        logic inf;
        send(16'h3C00, 1'b0, ac0, st);
        send(16'h3C00, 1'b1, ac1, st);
        watch_out(40, fc, d, np, inf);
        checks++; if (ac1 - ac0 != 1) begin failures++; $display("FAIL pair_contiguous: got %0d want 1", ac1 - ac0); end
        // one fold issue: FOLD at +2, result back at +9, OUT at +11
        checks++; if (fc - ac0 != 11) begin failures++; $display("FAIL pair_latency: got %0d want 11", fc - ac0); end
        checks++; if (d !== 16'h4000) begin failures++; $display("FAIL pair_data: got %h want 4000", d); end
        checks++; if (np != 1) begin failures++; $display("FAIL pair_pulses: got %0d want 1", np); end
        checks++; if ((add_a !== 16'h3C00) || (add_b !== 16'h3C00)) begin
            failures++; $display("FAIL pair_operands: got %h,%h want 3c00,3c00", add_a, add_b);
        end
`ifdef FLOAT_VEC_ACC_INF_DET_EN
        checks++; if (inf !== 1'b0) begin failures++; $display("FAIL pair_out_inf: got %b want 0", inf); end
`endif
    endtask

    task automatic test_contiguous();
        int ac, st, first_ac, last_ac, stall_tot, fc, np;
        logic [15:0] d;
        logic inf;
        stall_tot = 0;
        first_ac  = 0;
        last_ac   = 0;
        for (int e = 0; e < 12; e++) begin
            send(16'h3C00, (e == 11), ac, st);
            if (e == 0) first_ac = ac;
            last_ac   = ac;
            stall_tot += st;
        end
        watch_out(120, fc, d, np, inf);
        checks++; if (stall_tot != 0) begin failures++; $display("FAIL contig_stalls: got %0d want 0", stall_tot); end
        checks++; if (last_ac - first_ac != 11) begin failures++; $display("FAIL contig_span: got %0d want 11", last_ac - first_ac); end
        checks++; if (d !== 16'h4A00) begin failures++; $display("FAIL contig_data: got %h want 4a00", d); end
        checks++; if (np != 1) begin failures++; $display("FAIL contig_pulses: got %0d want 1", np); end
    endtask

    task automatic test_toggle();
        int ac, st, first_ac, last_ac, stall_tot, fc, np;
        logic [15:0] d;
        logic inf;
        stall_tot = 0;
        first_ac  = 0;
        last_ac   = 0;
        for (int e = 0; e < 12; e++) begin
            send(16'h3C00, (e == 11), ac, st);
            if (e == 0) first_ac = ac;
            last_ac   = ac;
            stall_tot += st;
            if (e != 11) @(negedge clock);
        end
        watch_out(120, fc, d, np, inf);
        // only slot 0 is revisited while in flight (issued at +6, busy until +13, requested at +12)
        checks++; if (stall_tot != 1) begin failures++; $display("FAIL toggle_stalls: got %0d want 1", stall_tot); end
        checks++; if (last_ac - first_ac != 23) begin failures++; $display("FAIL toggle_span: got %0d want 23", last_ac - first_ac); end
        checks++; if (d !== 16'h4A00) begin failures++; $display("FAIL toggle_data: got %h want 4a00", d); end
        checks++; if (np != 1) begin failures++; $display("FAIL toggle_pulses: got %0d want 1", np); end
    endtask

    task automatic test_reset_in_fold();
        int ac, st, fc, np, seen;
        logic [15:0] d;
        logic inf;
        send(16'h4000, 1'b0, ac, st);
        send(16'h4000, 1'b1, ac, st);
        repeat (2) @(negedge clock);
        rst_n = 1'b0;
        seen  = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rfold_out_valid_in_reset: got %0d pulses want 0", seen); end
        rst_n = 1'b1;
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rfold_in_ready: got %b want 1", in_ready); end
        checks++; if (add_a !== 16'h0) begin failures++; $display("FAIL rfold_add_a: got %h want 0000", add_a); end
        watch_out(30, fc, d, np, inf);
        checks++; if (np != 0) begin failures++; $display("FAIL rfold_stale_out: got %0d pulses want 0", np); end
        send(16'h4000, 1'b0, ac, st);
        send(16'h4000, 1'b1, ac, st);
        watch_out(40, fc, d, np, inf);
        checks++; if (d !== 16'h4400) begin failures++; $display("FAIL rfold_next_data: got %h want 4400", d); end
        checks++; if (np != 1) begin failures++; $display("FAIL rfold_next_pulses: got %0d want 1", np); end
    endtask

    task automatic test_inf();
        int ac, st, fc, np;
        logic [15:0] d;
        logic inf;
        send(16'h7BFF, 1'b0, ac, st);
        send(16'h7BFF, 1'b1, ac, st);
        watch_out(40, fc, d, np, inf);
        checks++; if (d !== 16'h7C00) begin failures++; $display("FAIL inf_data: got %h want 7c00", d); end
        checks++; if (np != 1) begin failures++; $display("FAIL inf_pulses: got %0d want 1", np); end
`ifdef FLOAT_VEC_ACC_INF_DET_EN
        checks++; if (inf !== 1'b1) begin failures++; $display("FAIL inf_flag: got %b want 1", inf); end
        checks++; if (out_inf_w !== 1'b0) begin failures++; $display("FAIL inf_flag_clear: got %b want 0", out_inf_w); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_contiguous();
        test_toggle();
        test_reset_in_fold();
        test_inf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/float_vec_acc.md
FLOAT_VEC_ACC -- requirements
Module: float_vec_acc

Interface
REQ-001 SHALL have parameter: ADD_LAT, default 6, fixed latency in cycles of the external float16 adder (add_a/add_b to add_c).
REQ-002 SHALL have port: clock  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  input element valid.
REQ-005 SHALL have port: in_ready  output  1  element accepted when in_valid&in_ready.
REQ-006 SHALL have port: in_data  input  16  float16 element {sign,exp[4:0],frac[9:0]}.
REQ-007 SHALL have port: in_last  input  1  marks final element of vector; vectors have at least one element.
REQ-008 SHALL have port: add_a  output  16  adder operand A (partial sum).
REQ-009 SHALL have port: add_b  output  16  adder operand B (element or second partial).
REQ-010 SHALL have port: add_c  input  16  adder result, valid ADD_LAT cycles after issue.
REQ-011 SHALL have port: out_valid  output  1  one-cycle pulse, vector sum valid.
REQ-012 SHALL have port: out_data  output  16  float16 vector sum.

Function
REQ-013 SHALL hold ADD_LAT slot registers, each with empty and in-flight flags; in-flight slot never issued or written except by its returning result.
REQ-014 SHALL implement FSM IDLE, ACCUM, FOLD, OUT; IDLE->ACCUM on accepted non-last element; IDLE or ACCUM->FOLD on accepted in_last; FOLD->OUT when exactly one slot non-empty and none in flight; OUT->IDLE unconditionally after one cycle.
REQ-015 SHALL drive in_ready=1 in IDLE, in_ready=!inflight[ptr] in ACCUM, 0 in FOLD and OUT.
REQ-016 SHALL reset slot pointer ptr to 0 in IDLE and advance it by 1 mod ADD_LAT every cycle in IDLE-accept and ACCUM, regardless of acceptance.
REQ-017 SHALL, on acceptance into an empty slot[ptr], store in_data directly (no adder issue) and clear empty.
REQ-018 SHALL, on acceptance into a non-empty slot[ptr], issue add_a=slot[ptr], add_b=in_data, set inflight[ptr], and push tag {valid,ptr} into an ADD_LAT-deep tag line.
REQ-019 SHALL, when a valid tag emerges, write add_c into slot[tag] and clear inflight[tag] in the same cycle.
REQ-020 SHALL, in FOLD, each cycle select the two lowest-index slots i<j that are non-empty and not in flight, issue add_a=slot[i], add_b=slot[j], mark j empty, mark i in flight, and tag i.
REQ-021 SHALL in OUT assert out_valid=1 with out_data=the single non-empty slot, then clear all slots to empty.
REQ-022 SHALL hold add_a/add_b at last value when not issuing; tag valid=0 on non-issue cycles.
REQ-023 SHALL pass float16 words unmodified; all arithmetic delegated to the external adder.

Reset
REQ-024 SHALL on rst_n low: state=IDLE, ptr=0, all slots empty, inflight=0, tag line cleared, out_valid=0, out_data=0, add_a=0, add_b=0, in_ready=1 after release.
REQ-025 SHALL discard adder results in flight at reset (tag line cleared).

Configuration
REQ-026 SHALL, with macro FLOAT_VEC_ACC_INF_DET_EN defined, add output out_inf (1 bit), set with out_valid when any written add_c had exp=5'h1F during the vector, reset 0; without it, port and logic absent.

Structure
REQ-027 SHALL place in package float_acc_pkg: FP16 width 16, exponent/fraction widths 5/10, FP16_EXP_MAX=5'h1F, FSM state enum.
REQ-028 SHALL use one sub-module float_acc_tagline: ADD_LAT-stage shift register of {valid, slot index}, async active-low clear.

Verification (ADD_LAT=6, bench models adder as exact float16 add, delay 6)
REQ-029 SHALL test single element 16'h3C00 with in_last -> out_valid exactly 2 cycles after acceptance, out_data=16'h3C00, no adder issue.
REQ-030 SHALL test two elements 16'h3C00,16'h3C00 back-to-back -> one FOLD issue, out_data=16'h4000, single out_valid pulse.
REQ-031 SHALL test 12 contiguous 16'h3C00 -> in_ready stays 1 throughout, out_data=16'h4A00.
REQ-032 SHALL test 12 elements 16'h3C00 with in_valid toggling every other cycle -> in_ready drops only on in-flight slots, out_data=16'h4A00.
REQ-033 SHALL test rst_n low during FOLD -> out_valid stays 0, in_ready=1 after release, next vector 16'h4000,16'h4000 gives 16'h4400.
REQ-034 SHALL test with FLOAT_VEC_ACC_INF_DET_EN: 16'h7BFF+16'h7BFF -> out_inf=1 with out_valid; without macro, same vector builds and completes.
